// File: rtl/cp0_exception_if.sv
// Commit-stage interface between the pipeline and the CP0 exception unit.
// The pipeline side is the master; the CP0 block is the slave.
interface cp0_exception_if;
   logic        commit_valid;
   logic [31:0] commit_pc;
   logic        in_delay_slot;
   logic        ri;
   logic        sys;
   logic        bp;
   logic        ov;
   logic        adel_if;
   logic        adel_ld;
   logic        ades;
   logic [31:0] bad_addr;
   logic        eret;
   logic        cp0_Write;
   logic        mfc0;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic [5:0]  hw_int;
   logic [31:0] cp0_rdata;
   logic        exc_flush;
   logic [31:0] exc_pc;
   logic [31:0] epc_out;

   modport master (
      output commit_valid, commit_pc, in_delay_slot, ri, sys, bp, ov,
             adel_if, adel_ld, ades, bad_addr, eret, cp0_Write, mfc0,
             cp0_addr, cp0_wdata, hw_int,
      input  cp0_rdata, exc_flush, exc_pc, epc_out
   );

   modport slave (
      input  commit_valid, commit_pc, in_delay_slot, ri, sys, bp, ov,
             adel_if, adel_ld, ades, bad_addr, eret, cp0_Write, mfc0,
             cp0_addr, cp0_wdata, hw_int,
      output cp0_rdata, exc_flush, exc_pc, epc_out
   );
endinterface

// File: rtl/cp0_exception_unit.sv
// Coprocessor-0: BadVAddr/Count/Compare/Status/Cause/EPC, exception and interrupt
// prioritisation at commit, and PC redirect with a combinational flush.
module cp0_exception_unit #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter int          COUNT_DIV  = 2
) (
   input logic            clk,
   input logic            rst,
   cp0_exception_if.slave bus
);
   localparam int          DIV_W         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [31:0] STATUS_WMASK  = 32'h0000_FF03;
   localparam logic [31:0] STATUS_RESET  = 32'h0040_0000;

   logic [31:0] badvaddr, count, compare, status, epc;
   logic        bd, ti;
   logic [5:0]  hw_q;
   logic [1:0]  sw_ip;
   logic [4:0]  exc_code;
   logic [DIV_W-1:0] div;

   logic [7:0]  cause_ip;
   logic [31:0] cause;
   logic        valid, int_req, exc_take, eret_take, wr, wr_count, div_last;
   logic [4:0]  code;
   logic        bv_load;
   logic [31:0] bv_val;
   logic [31:0] count_nxt;
   logic [DIV_W-1:0] div_nxt;
   logic        ti_nxt;

   assign valid    = bus.commit_valid;
   assign cause_ip = {hw_q[5] | ti, hw_q[4:0], sw_ip};
   assign cause    = {bd, ti, 14'd0, cause_ip, 1'b0, exc_code, 2'b00};
   assign int_req  = valid & status[0] & ~status[1] & (|(cause_ip & status[15:8]));

   always_comb begin
      exc_take = 1'b1;
      code     = 5'h00;
      bv_load  = 1'b0;
      bv_val   = bus.bad_addr;
      if (int_req) begin
         code = 5'h00;
      end else if (valid && bus.adel_if) begin
         code    = 5'h04;
         bv_load = 1'b1;
         bv_val  = bus.commit_pc;
      end else if (valid && bus.ri) begin
         code = 5'h0A;
      end else if (valid && bus.ov) begin
         code = 5'h0C;
      end else if (valid && bus.sys) begin
         code = 5'h08;
      end else if (valid && bus.bp) begin
         code = 5'h09;
      end else if (valid && bus.adel_ld) begin
         code    = 5'h04;
         bv_load = 1'b1;
      end else if (valid && bus.ades) begin
         code    = 5'h05;
         bv_load = 1'b1;
      end else begin
         exc_take = 1'b0;
      end
   end

   // Any exception squashes the committing instruction's own mtc0/eret effects.
   assign eret_take = valid & bus.eret & ~exc_take;
   assign wr        = valid & bus.cp0_Write & ~exc_take;
   assign wr_count  = wr & (bus.cp0_addr == 5'd9);
   assign div_last  = (div == DIV_W'(COUNT_DIV - 1));

   assign bus.exc_flush = ~rst & (exc_take | eret_take);
   assign bus.exc_pc    = exc_take ? EXC_VECTOR : epc;
   assign bus.epc_out   = epc;

   // TI only fires on a real increment, so Count==Compare==0 out of reset is not a hit.
   always_comb begin
      count_nxt = div_last ? count + 32'd1 : count;
      div_nxt   = div_last ? '0 : div + DIV_W'(1);
      ti_nxt    = ti | (div_last & (count + 32'd1 == compare));
      if (wr_count) begin
         count_nxt = bus.cp0_wdata;
         div_nxt   = '0;
         ti_nxt    = ti;
      end
      if (wr && bus.cp0_addr == 5'd11) ti_nxt = 1'b0;
   end

   always_comb begin
      case (bus.cp0_addr)
         5'd8:    bus.cp0_rdata = badvaddr;
         5'd9:    bus.cp0_rdata = count;
         5'd11:   bus.cp0_rdata = compare;
         5'd12:   bus.cp0_rdata = status;
         5'd13:   bus.cp0_rdata = cause;
         5'd14:   bus.cp0_rdata = epc;
         default: bus.cp0_rdata = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         badvaddr <= 32'd0;
         count    <= 32'd0;
         compare  <= 32'd0;
         status   <= STATUS_RESET;
         epc      <= 32'd0;
         bd       <= 1'b0;
         ti       <= 1'b0;
         hw_q     <= 6'd0;
         sw_ip    <= 2'd0;
         exc_code <= 5'd0;
         div      <= '0;
      end else begin
         count <= count_nxt;
         div   <= div_nxt;
         ti    <= ti_nxt;
         hw_q  <= bus.hw_int;
         if (wr) begin
            case (bus.cp0_addr)
               5'd11:   compare <= bus.cp0_wdata;
               5'd12:   status  <= (status & ~STATUS_WMASK) | (bus.cp0_wdata & STATUS_WMASK);
               5'd13:   sw_ip   <= bus.cp0_wdata[9:8];
               5'd14:   epc     <= bus.cp0_wdata;
               default: ;
            endcase
         end
         if (exc_take) begin
            exc_code  <= code;
            status[1] <= 1'b1;
            if (!status[1]) begin
               epc <= bus.in_delay_slot ? bus.commit_pc - 32'd4 : bus.commit_pc;
               bd  <= bus.in_delay_slot;
            end
            if (bv_load) badvaddr <= bv_val;
         end
         if (eret_take) status[1] <= 1'b0;
      end
   end
endmodule
